// File: rtl/stream_ctrl_burst.sv
// stream_ctrl_burst: output-stream controller for the result path.
// Queues accelerator completion pulses. For each one it emits a burst of
// buffer read strobes/addresses, plus registered dst_valid/dst_last toward
// the stream sink.
// Optional build macro: STREAM_CTRL_FIN_SYNC_EN adds a two-flop delay on
// get_fin so the core array completion tree has time to settle.
`timescale 1ns/1ps

module stream_ctrl_burst #(
  parameter int AW     = 8,
  parameter int PEND_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          get_fin,
  input  logic [AW-1:0] burst_len,
  input  logic          dst_ready,
  output logic          stream_v,
  output logic [AW-1:0] stream_a,
  output logic          dst_valid,
  output logic          dst_last,
  output logic          busy,
  output logic          overflow
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_d;
  logic [AW-1:0]     addr, addr_d;
  logic [AW-1:0]     len_q, len_d;
  logic [PEND_W-1:0] pend;
  logic              fin_evt;
  logic              start;
  logic              pend_nz;

  // ---- stage p0/p1: completion event alignment ----
`ifdef STREAM_CTRL_FIN_SYNC_EN
  logic fin_p0, fin_p1;

  // Delay the completion pulse by two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_p0 <= 1'b0;
      fin_p1 <= 1'b0;
    end else begin
      fin_p0 <= get_fin;
      fin_p1 <= fin_p0;
    end
  end

  assign fin_evt = fin_p1;
`else
  assign fin_evt = get_fin;
`endif

  assign pend_nz  = (pend != '0);
  assign stream_v = (state == STREAM) && dst_ready;
  assign stream_a = addr;
  assign busy     = (state == STREAM) || pend_nz;

  // ---- burst sequencing ----
  // Next-state logic: start a burst, step the address, restart back-to-back or retire.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    len_d   = len_q;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_nz && dst_ready) begin
          start   = 1'b1;
          state_d = STREAM;
          addr_d  = '0;
          len_d   = burst_len;
        end
      end
      STREAM: begin
        if (dst_ready) begin
          if (addr != len_q) begin
            addr_d = addr + 1'b1;
          end else if (pend_nz) begin
            // Last beat with work queued: next burst follows with no gap.
            start  = 1'b1;
            addr_d = '0;
            len_d  = burst_len;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, beat address and latched burst length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      len_q <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      len_q <= len_d;
    end
  end

  // Pending-completion counter; saturates and flags a lost completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      if (fin_evt && !start) begin
        if (pend == PEND_MAX) begin
          overflow <= 1'b1;
        end else begin
          pend <= pend + 1'b1;
        end
      end else if (!fin_evt && start) begin
        pend <= pend - 1'b1;
      end
    end
  end

  // ---- stage p2: output register, aligned with one-cycle buffer read ----
  // Output flags advance only with the sink, so valid never drops without a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_valid <= 1'b0;
      dst_last  <= 1'b0;
    end else if (dst_ready) begin
      dst_valid <= stream_v;
      dst_last  <= stream_v && (addr == len_q);
    end
  end

endmodule

// File: doc/stream_ctrl_burst.md
# stream_ctrl_burst

Output-stream controller for the result path: counts accelerator completion pulses and, for each one, emits a multi-beat burst of read strobes/addresses into the result buffer plus the matching registered dst_valid/dst_last toward the DMA/stream sink. It replaces the single-beat controller with a runtime burst length, a queue of pending completions and an explicit read address. It sits between the core array's completion signal and the stream output register stage.

## Interface
- AW, default 8: width of burst length and buffer read address; max burst = 2^AW beats.
- PEND_W, default 2: width of pending-completion counter; max queued completions = 2^PEND_W − 1.

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- get_fin  in  1  one-cycle completion pulse from the core array.
- burst_len  in  AW  beats minus one for the next burst; sampled at burst start.
- dst_ready  in  1  sink ready; the whole pipeline advances only when high.
- stream_v  out  1  combinational buffer read enable for the current beat.
- stream_a  out  AW  buffer read address for the current beat.
- dst_valid  out  1  registered output valid.
- dst_last  out  1  registered last-beat flag.
- busy  out  1  high while a burst is active or completions are pending.
- overflow  out  1  sticky: a completion arrived with the pending counter saturated.

## Operation
- fin_evt: get_fin, or its delayed form per Configuration.
- pend (PEND_W bits): +1 on fin_evt, −1 on burst start, unchanged if both happen in the same cycle. At max with fin_evt and no start: holds and sets overflow. overflow clears only on reset.
- FSM states IDLE, STREAM.
  - IDLE → STREAM when pend != 0 and dst_ready: latch len_q = burst_len, addr = 0, pend −1.
  - STREAM, dst_ready high: stream_v = 1, stream_a = addr. If addr != len_q, addr +1.
  - STREAM, addr == len_q, dst_ready: last beat. If pend != 0, restart back-to-back (addr = 0, re-latch burst_len, pend −1, stay STREAM). Otherwise go to IDLE.
  - STREAM, dst_ready low: stream_v = 0; addr, state and len_q hold.
- stream_v = (state == STREAM) & dst_ready. stream_a = addr. Both are purely combinational.
- On dst_ready only: dst_valid <= stream_v; dst_last <= stream_v & (addr == len_q). With dst_ready low both hold, so dst_valid never drops without a transfer.
- busy = (state == STREAM) | (pend != 0).
- addr never wraps: it stops at len_q ≤ 2^AW − 1.

## Timing
- Reset values: state IDLE, pend 0, addr 0, len_q 0, overflow 0, dst_valid 0, dst_last 0, delay flops 0. Consequently stream_v, stream_a and busy are 0.
- Asserting rst_n low mid-burst aborts immediately. No dst_last is produced. Pending completions are discarded.
- Macro off, dst_ready held high:
  - get_fin at cycle 0 → pend = 1 at cycle 1.
  - STREAM at cycle 2, stream_v/stream_a = 0 at cycle 2.
  - dst_valid at cycle 3.
  - Burst of N = burst_len + 1 beats: dst_valid high cycles 3..N+2, dst_last at cycle N+2.
- Macro on: all of the above shifted by +2 cycles.
- Buffer read latency is 1 cycle. Data registered on dst_ready aligns with dst_valid.
- Back-to-back bursts: no idle cycle between the dst_last of one burst and the first beat of the next.

## Configuration
- STREAM_CTRL_FIN_SYNC_EN defined: fin_evt = get_fin delayed through two flops. This is for variable core count, where the array completion tree needs two extra cycles to settle.
- STREAM_CTRL_FIN_SYNC_EN undefined: fin_evt = get_fin, with no added latency.

## Test plan
- Macro off, burst_len = 0, dst_ready = 1, single get_fin at cycle 0 → stream_a = 0 at cycle 2; dst_valid = dst_last = 1 at cycle 3 only.
- burst_len = 3, dst_ready = 1 → stream_a 0,1,2,3 on cycles 2–5; dst_valid cycles 3–6; dst_last at cycle 6 only; busy low from cycle 6.
- burst_len = 3, dst_ready low on cycles 3–4 → stream_v low on cycles 3–4, stream_a holds 1; dst_valid/dst_last hold; dst_last at cycle 8.
- Three get_fin pulses on cycles 0–2, burst_len = 1 → pend peaks at 2; six consecutive dst_valid beats with dst_last on the 2nd, 4th and 6th; overflow = 0.
- PEND_W = 2, dst_ready = 0, five get_fin pulses → pend saturates at 3, overflow = 1 and stays set; releasing dst_ready yields exactly 3 bursts.
- rst_n pulsed low mid-burst → all outputs 0 asynchronously; after release, a new get_fin produces a fresh burst starting at stream_a = 0. Repeat with the macro on: first dst_valid at cycle 5.
